// File: rtl/mux_scan_reg_if.sv
// ---------------------------------------------------------------------------
// mux_scan_reg_if
// Bundles the channel inputs, control strobes and registered sample outputs
// of mux_scan_reg.
//   data_in   : CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   sel       : manual channel select
//   mode      : 0 = manual select, 1 = auto-scan
//   enable    : capture request
//   out_ready : downstream accept
//   out_data  : registered sample of the selected channel
//   out_ch    : channel index of out_data
//   out_valid : out_data/out_ch hold an unaccepted sample
//   err       : sticky out-of-range manual select flag
// Modports: master = the side driving inputs, slave = mux_scan_reg itself.
// ---------------------------------------------------------------------------
interface mux_scan_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) ();
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      enable;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_ch;
  logic                      out_valid;
  logic                      err;

  modport master (
    output data_in, sel, mode, enable, out_ready,
    input  out_data, out_ch, out_valid, err
  );

  modport slave (
    input  data_in, sel, mode, enable, out_ready,
    output out_data, out_ch, out_valid, err
  );
endinterface

// File: rtl/mux_scan_reg.sv
// ---------------------------------------------------------------------------
// mux_scan_reg
// Captures one of CHANNELS input channels into a single-entry output
// register with a valid/ready handshake. The channel comes either from the
// manual select (sel) or from an internal scan pointer that steps to the
// next channel after DWELL captures.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : mux_scan_reg_if.slave (data_in, sel, mode, enable, out_ready in;
//            out_data, out_ch, out_valid, err out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module mux_scan_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  mux_scan_reg_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);
  localparam int DCW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SELW:0]   NUM_CH  = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
  localparam logic [DCW-1:0]  LAST_DW = DCW'(DWELL - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [DCW-1:0]  dwell;
  logic            mode_q;

  logic             capture;
  logic             auto_entry;
  logic             sel_ok;
  logic [SELW-1:0]  eff_ptr;
  logic [DCW-1:0]   eff_dwell;
  logic [SELW-1:0]  ch;
  logic [WIDTH-1:0] ch_data;
  logic [SELW-1:0]  ptr_next;
  logic [DCW-1:0]   dwell_next;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    capture    = bus.enable && ((state == EMPTY) || bus.out_ready);
    // First auto cycle after manual: scan restarts from channel 0, dwell 0.
    auto_entry = bus.mode && !mode_q;
    eff_ptr    = auto_entry ? '0 : ptr;
    eff_dwell  = auto_entry ? '0 : dwell;
    sel_ok     = {1'b0, bus.sel} < NUM_CH;

    ch = '0;
    if (bus.mode) begin
      ch = eff_ptr;
    end else if (sel_ok) begin
      ch = bus.sel;
    end
    ch_data = bus.data_in[ch*WIDTH +: WIDTH];

    // Explicit wrap so a non-power-of-two channel count never reaches an
    // unused index.
    ptr_next   = eff_ptr;
    dwell_next = eff_dwell + 1'b1;
    if (eff_dwell == LAST_DW) begin
      dwell_next = '0;
      ptr_next   = (eff_ptr == LAST_CH) ? '0 : eff_ptr + 1'b1;
    end
  end

  assign bus.out_valid = (state == FULL);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  // NOTE: the asynchronous reset clears the held sample too; a sample held
  // under backpressure is deliberately discarded.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.err      <= 1'b0;
      ptr          <= '0;
      dwell        <= '0;
      mode_q       <= 1'b0;
    end else begin
      mode_q <= bus.mode;

      // Scan restart is committed on the entry cycle even when it does not
      // capture, so the pointer starts from 0 whenever the first capture lands.
      if (auto_entry) begin
        ptr   <= '0;
        dwell <= '0;
      end

      if (capture) begin
        state        <= FULL;
        bus.out_data <= ch_data;
        bus.out_ch   <= ch;
        if (bus.mode) begin
          ptr   <= ptr_next;
          dwell <= dwell_next;
        end else if (!sel_ok) begin
          bus.err <= 1'b1;
        end
      end else if ((state == FULL) && bus.out_ready) begin
        // Drain: data and channel keep their last values.
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_reg
// Two instances: CHANNELS=4/DWELL=2 (main) and CHANNELS=3/DWELL=1 (odd
// channel count, out-of-range select, advance on every capture). A reference
// model tracks the number of auto captures since scan entry and derives the
// channel as (count / DWELL) % CHANNELS; a negedge process compares both
// instances with it every cycle. Directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_mux_scan_reg;
  logic Clock;
  logic Resetn;

  mux_scan_reg_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  mux_scan_reg_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  mux_scan_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_dut4 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus4)
  );

  mux_scan_reg #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut3 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  typedef struct {
    bit valid;
    int data;
    int ch;
    bit err;
    int count;      // auto captures since the last entry into auto mode
    bit prev_mode;
  } model_t;

  function automatic model_t model_next(model_t m, logic [31:0] din, int sel, bit mode,
                                        bit en, bit rdy, int chans, int dwell);
    model_t n = m;
    int     c = 0;
    if (mode && !m.prev_mode) n.count = 0;
    if (en && (!m.valid || rdy)) begin
      if (mode) begin
        c = (n.count / dwell) % chans;
        n.count++;
      end else if (sel < chans) begin
        c = sel;
      end else begin
        c = 0;
        n.err = 1'b1;
      end
      n.data  = int'((din >> (c * 8)) & 32'hff);
      n.ch    = c;
      n.valid = 1'b1;
    end else if (m.valid && rdy) begin
      n.valid = 1'b0;
    end
    n.prev_mode = mode;
    return n;
  endfunction

  model_t m4 = '{default: 0};
  model_t m3 = '{default: 0};

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m4 = '{default: 0};
      m3 = '{default: 0};
    end else begin
      m4 = model_next(m4, bus4.data_in, int'(bus4.sel), bus4.mode, bus4.enable,
                      bus4.out_ready, 4, 2);
      m3 = model_next(m3, {8'h00, bus3.data_in}, int'(bus3.sel), bus3.mode, bus3.enable,
                      bus3.out_ready, 3, 1);
    end
  end

  // ---- per-cycle comparison ----------------------------------------------
  always @(negedge Clock) begin
    if (cmp_en) begin
      check("c4 out_valid", {31'd0, bus4.out_valid}, {31'd0, m4.valid});
      check("c4 out_data",  {24'd0, bus4.out_data},  m4.data);
      check("c4 out_ch",    {30'd0, bus4.out_ch},    m4.ch);
      check("c4 err",       {31'd0, bus4.err},       {31'd0, m4.err});
      check("c3 out_valid", {31'd0, bus3.out_valid}, {31'd0, m3.valid});
      check("c3 out_data",  {24'd0, bus3.out_data},  m3.data);
      check("c3 out_ch",    {30'd0, bus3.out_ch},    m3.ch);
      check("c3 err",       {31'd0, bus3.err},       {31'd0, m3.err});
    end
  end

  task automatic expect4(input string name, input bit v, input int d, input int c);
    check({name, " valid"}, {31'd0, bus4.out_valid}, {31'd0, v});
    check({name, " data"},  {24'd0, bus4.out_data},  d);
    check({name, " ch"},    {30'd0, bus4.out_ch},    c);
  endtask

  int exp_ch[10]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_data[10] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11, 'h11};

  initial begin
    Resetn         = 1'b0;
    bus4.data_in   = 32'h44332211;
    bus4.sel       = '0;
    bus4.mode      = 1'b0;
    bus4.enable    = 1'b0;
    bus4.out_ready = 1'b0;
    bus3.data_in   = 24'h332211;
    bus3.sel       = '0;
    bus3.mode      = 1'b0;
    bus3.enable    = 1'b0;
    bus3.out_ready = 1'b0;

    // Reset state
    #12;
    expect4("reset", 1'b0, 0, 0);
    check("reset err", {31'd0, bus4.err}, 32'd0);
    check("reset c3 valid", {31'd0, bus3.out_valid}, 32'd0);

    @(negedge Clock);
    Resetn = 1'b1;
    cmp_en = 1'b1;

    // Manual select, first edge after reset release
    bus4.sel = 2'd2; bus4.enable = 1'b1; bus4.out_ready = 1'b1;
    @(posedge Clock); #1;
    expect4("manual", 1'b1, 'h33, 2);

    // Backpressure holds the sample whatever sel does
    @(negedge Clock);
    bus4.out_ready = 1'b0; bus4.sel = 2'd1;
    repeat (3) begin
      @(posedge Clock); #1;
      expect4("stall", 1'b1, 'h33, 2);
    end
    @(negedge Clock);
    bus4.out_ready = 1'b1;
    @(posedge Clock); #1;
    expect4("release", 1'b1, 'h22, 1);

    // Auto scan from a fresh entry
    @(negedge Clock);
    bus4.mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      expect4($sformatf("auto%0d", i), 1'b1, exp_data[i], exp_ch[i]);
    end

    // Drain keeps data and channel
    @(negedge Clock);
    bus4.enable = 1'b0;
    @(posedge Clock); #1;
    expect4("drain", 1'b0, 'h11, 0);

    // Re-enter auto and stop at ptr=2 under backpressure
    @(negedge Clock);
    bus4.mode = 1'b0;
    @(negedge Clock);
    bus4.mode = 1'b1; bus4.enable = 1'b1;
    repeat (5) @(posedge Clock);
    #1;
    expect4("pre-reset", 1'b1, 'h33, 2);
    @(negedge Clock);
    bus4.out_ready = 1'b0;
    @(posedge Clock); #3;
    Resetn = 1'b0;
    #1;
    expect4("async reset", 1'b0, 0, 0);
    #2;
    Resetn = 1'b1;
    bus4.out_ready = 1'b1;
    @(posedge Clock); #1;
    expect4("post-reset auto", 1'b1, 'h11, 0);

    // Out-of-range manual select on the 3-channel instance
    @(negedge Clock);
    bus4.enable = 1'b0;
    bus3.sel = 2'd3; bus3.enable = 1'b1; bus3.out_ready = 1'b1;
    @(posedge Clock); #1;
    check("oor ch",   {30'd0, bus3.out_ch},   32'd0);
    check("oor data", {24'd0, bus3.out_data}, 32'h11);
    check("oor err",  {31'd0, bus3.err},      32'd1);
    @(negedge Clock);
    bus3.sel = 2'd1;
    @(posedge Clock); #1;
    check("sticky ch",   {30'd0, bus3.out_ch},   32'd1);
    check("sticky data", {24'd0, bus3.out_data}, 32'h22);
    check("sticky err",  {31'd0, bus3.err},      32'd1);

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      if (i == 1500) begin
        #2 Resetn = 1'b0;
        #1 Resetn = 1'b1;
      end
      bus4.data_in   = $urandom;
      bus4.sel       = 2'($urandom);
      if ($urandom_range(0, 7) == 0) bus4.mode = ~bus4.mode;
      bus4.enable    = ($urandom_range(0, 3) != 0);
      bus4.out_ready = ($urandom_range(0, 2) != 0);
      bus3.data_in   = 24'($urandom);
      bus3.sel       = 2'($urandom);
      if ($urandom_range(0, 7) == 0) bus3.mode = ~bus3.mode;
      bus3.enable    = ($urandom_range(0, 3) != 0);
      bus3.out_ready = ($urandom_range(0, 2) != 0);
    end

    @(negedge Clock);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_scan_reg.md
MUX_SCAN_REG -- requirements
Module: mux_scan_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits per channel (WIDTH >= 1).
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of input channels (CHANNELS >= 2).
REQ-003 The block SHALL have parameter DWELL, default 4, giving the captures per channel in auto-scan mode (DWELL >= 1).
REQ-004 The block SHALL derive localparam SELW = ceil(log2(CHANNELS)).
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port data_in, input, CHANNELS*WIDTH bits, with channel k at bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SELW bits: the manual channel select.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-010 The block SHALL have port enable, input, 1 bit: capture request.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the registered selected channel data.
REQ-013 The block SHALL have port out_ch, output, SELW bits: the channel index of out_data.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data/out_ch hold an unaccepted sample.
REQ-015 The block SHALL have port err, output, 1 bit: sticky flag for an out-of-range manual select.

Function
REQ-016 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 A capture SHALL occur on a rising Clock edge when enable=1 and (out_valid=0 or out_ready=1).
REQ-018 On capture, out_data SHALL take data_in channel ch, out_ch SHALL take ch, and the state SHALL become FULL; the latency from input to output SHALL be one cycle.
REQ-019 The block SHALL make these state transitions:
- EMPTY -> FULL on capture, otherwise stay in EMPTY.
- FULL with out_ready=0: hold out_data, out_ch and out_valid unchanged, whatever sel, mode or data_in do.
- FULL with out_ready=1 and capture: stay in FULL with the new sample; no bubble.
- FULL with out_ready=1 and enable=0: go to EMPTY; out_data and out_ch keep their last values.
REQ-020 In manual mode (mode=0), ch SHALL equal sel when sel < CHANNELS; otherwise ch SHALL be 0 and err SHALL be set on that capture.
REQ-021 The err flag SHALL be set only on a capture and SHALL stay at 1 until reset.
REQ-022 In auto mode (mode=1), ch SHALL equal the internal scan pointer ptr (SELW bits), and sel SHALL be ignored.
REQ-023 A dwell counter SHALL increment on each auto-mode capture; on the capture where it equals DWELL-1, the counter SHALL clear and ptr SHALL advance by one.
REQ-024 The scan pointer ptr SHALL wrap from CHANNELS-1 to 0, including when CHANNELS is not a power of two.
REQ-025 In the first cycle with mode=1 after mode=0 (detected by a registered mode_q), ptr and the dwell counter SHALL behave as 0 for that cycle's capture and update from there.
REQ-026 Switching from auto to manual SHALL freeze ptr and the dwell counter, and REQ-025 SHALL restart them on the next entry to auto mode.
REQ-027 The ptr and dwell counter SHALL not change on cycles without a capture, including backpressure stalls.
REQ-028 With DWELL=1, ptr SHALL advance on every auto-mode capture.
REQ-029 The block SHALL be purely synchronous apart from Resetn and SHALL have no combinational path from inputs to outputs.

Reset
REQ-030 While Resetn=0, the block SHALL set out_data=0, out_ch=0, out_valid=0, err=0, ptr=0, dwell counter=0, mode_q=0 and state=EMPTY immediately, without needing a clock edge.
REQ-031 Asserting Resetn mid-transfer (FULL, out_ready=0) SHALL discard the held sample.
REQ-032 The first capture SHALL be possible on the first rising edge after Resetn deasserts.

Verification
REQ-033 The bench SHALL use WIDTH=8, CHANNELS=4, DWELL=2 and data_in = {8'h44,8'h33,8'h22,8'h11} (ch3..ch0) unless a scenario states otherwise, and SHALL cover these scenarios:
- Manual: mode=0, sel=2, enable=1, out_ready=1 -> after one edge, out_data=8'h33, out_ch=2, out_valid=1.
- Backpressure: FULL with 8'h33, out_ready=0, sel changed to 1 for 3 cycles -> out_data stays 8'h33; out_ready=1 -> next edge gives out_data=8'h22, out_ch=1.
- Auto scan: mode 0->1, enable=1, out_ready=1 for 10 edges -> out_ch sequence 0,0,1,1,2,2,3,3,0,0 with matching data 11,11,22,22,33,33,44,44,11,11.
- Drain and out-of-range: enable 1->0 with out_ready=1 -> out_valid=0 after one edge, out_data held. In a CHANNELS=3 instance, sel=3 capture -> out_ch=0, out_data=ch0 data, err=1, and err stays 1 after sel=1.
- Async reset: Resetn pulsed low between edges while FULL in auto mode at ptr=2 -> all outputs 0 immediately; the next auto capture starts at out_ch=0.
